// File: rtl/opdec_pkg.sv
// Shared types and constants for the operand decode pipeline: instruction
// classes, register-field positions and per-class register-read masks.
package opdec_pkg;

    typedef enum logic [1:0] {
        CLS_IMM    = 2'd0,
        CLS_MEM_BR = 2'd1,
        CLS_REG    = 2'd2
    } instr_cls_t;

    // Register fields are packed back to back from bit 0, one REG_ADDR_W slot each.
    localparam int F0_IDX = 0;
    localparam int F1_IDX = 1;
    localparam int F2_IDX = 2;

    // Read mask bit 0 = port A is a real read, bit 1 = port B is a real read.
    localparam logic [1:0] RD_A      = 2'b01;
    localparam logic [1:0] RD_B      = 2'b10;
    localparam logic [1:0] RDM_IMM   = RD_B;
    localparam logic [1:0] RDM_LOAD  = RD_A;
    localparam logic [1:0] RDM_ST_BR = RD_A | RD_B;
    localparam logic [1:0] RDM_REG   = RD_A | RD_B;

    function automatic instr_cls_t classify(input logic reg_dst, input logic mem_to_reg,
                                            input logic mem_write, input logic branch);
        if (!reg_dst)
            return CLS_IMM;
        else if (mem_to_reg | mem_write | branch)
            return CLS_MEM_BR;
        else
            return CLS_REG;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set on issue of a writer,
// cleared on writeback; a set beats a clear of the same register in one cycle.
module reg_scoreboard #(
    parameter int NUM_REGS = 4,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                set_en,
    input  logic [AW-1:0]       set_addr,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_addr,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    assign set_mask = set_en ? (NUM_REGS'(1) << set_addr) : '0;
    assign clr_mask = clr_en ? (NUM_REGS'(1) << clr_addr) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else if (flush)
            busy <= '0;
        else
            busy <= (busy & ~clr_mask) | set_mask;
    end

endmodule

// File: rtl/operand_decode_pipe.sv
// Register-field decoder with a valid/ready output register, RAW hazard stall
// against a write-pending scoreboard, flush, and a saturating stall counter.
module operand_decode_pipe
    import opdec_pkg::*;
#(
    parameter int INSTR_W    = 9,
    parameter int REG_ADDR_W = 2,
    parameter int IMM_W      = 4,
    parameter int OUT_W      = 8,
    parameter int STALL_CW   = 16
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    mach_code,
    input  logic                  RegDst,
    input  logic                  MemtoReg,
    input  logic                  MemWrite,
    input  logic                  Branch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      inA,
    output logic [OUT_W-1:0]      inB,
    output logic [OUT_W-1:0]      immediate,
    output logic [REG_ADDR_W-1:0] dst_addr,
    output logic                  dst_we,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    output logic [STALL_CW-1:0]   stall_cnt
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    instr_cls_t            cls;
    logic [REG_ADDR_W-1:0] f0, f1, f2;
    logic [REG_ADDR_W-1:0] rd_a, rd_b;
    logic [OUT_W-1:0]      imm_d;
    logic [1:0]            rd_mask;
    logic                  we_d;
    logic [NUM_REGS-1:0]   busy;
    logic                  hazard;
    logic                  accept;
    logic                  unused_code;

    assign f0 = mach_code[F0_IDX*REG_ADDR_W +: REG_ADDR_W];
    assign f1 = mach_code[F1_IDX*REG_ADDR_W +: REG_ADDR_W];
    assign f2 = mach_code[F2_IDX*REG_ADDR_W +: REG_ADDR_W];
    assign unused_code = ^mach_code;

    always_comb begin
        cls     = classify(RegDst, MemtoReg, MemWrite, Branch);
        rd_a    = f0;
        rd_b    = f1;
        imm_d   = OUT_W'(f0);
        rd_mask = RDM_REG;
        we_d    = 1'b1;
        case (cls)
            CLS_IMM: begin
                rd_a    = f0;
                rd_b    = f2;
                imm_d   = OUT_W'(mach_code[IMM_W-1:0]);
                rd_mask = RDM_IMM;
            end
            CLS_MEM_BR: begin
                rd_a    = f1;
                rd_b    = f2;
                imm_d   = '0;
                rd_mask = MemtoReg ? RDM_LOAD : RDM_ST_BR;
                we_d    = MemtoReg;
            end
            default: ;
        endcase
    end

    // Only operands the class really reads can raise a hazard.
    assign hazard   = in_valid & ((rd_mask[0] & busy[rd_a]) | (rd_mask[1] & busy[rd_b]));
    assign in_ready = Reset_n & (!out_valid | out_ready) & !hazard & !flush;
    assign accept   = in_valid & in_ready;

    reg_scoreboard #(.NUM_REGS(NUM_REGS), .AW(REG_ADDR_W)) u_sb (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .flush    (flush),
        .set_en   (accept & we_d),
        .set_addr (f0),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .busy     (busy)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            inA       <= '0;
            inB       <= '0;
            immediate <= '0;
            dst_addr  <= '0;
            dst_we    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            inA       <= OUT_W'(rd_a);
            inB       <= OUT_W'(rd_b);
            immediate <= imm_d;
            dst_addr  <= f0;
            dst_we    <= we_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            stall_cnt <= '0;
        else if (in_valid & !in_ready & !flush & ~&stall_cnt)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_operand_decode_pipe.sv
// Directed bench for operand_decode_pipe: a queue of expected decodes is filled
// on every accept and drained on every output transfer.
module tb_operand_decode_pipe;

    logic       Clk, Reset_n, flush, in_valid, in_ready;
    logic [8:0] mach_code;
    logic       RegDst, MemtoReg, MemWrite, Branch;
    logic       out_valid, out_ready;
    logic [7:0] inA, inB, immediate;
    logic [1:0] dst_addr;
    logic       dst_we;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [15:0] stall_cnt;

    operand_decode_pipe #(
        .INSTR_W(9), .REG_ADDR_W(2), .IMM_W(4), .OUT_W(8), .STALL_CW(16)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .mach_code(mach_code),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .Branch(Branch),
        .out_valid(out_valid), .out_ready(out_ready),
        .inA(inA), .inB(inB), .immediate(immediate),
        .dst_addr(dst_addr), .dst_we(dst_we),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .stall_cnt(stall_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] imm;
        logic [1:0] dst;
        logic       we;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [8:0] c, input logic rd, input logic ml,
                                   input logic mw, input logic br);
        exp_t e;
        e.dst = c[1:0];
        if (!rd) begin
            e.a = {6'b0, c[1:0]}; e.b = {6'b0, c[5:4]}; e.imm = {4'b0, c[3:0]}; e.we = 1'b1;
        end else if (ml | mw | br) begin
            e.a = {6'b0, c[3:2]}; e.b = {6'b0, c[5:4]}; e.imm = 8'd0; e.we = ml;
        end else begin
            e.a = {6'b0, c[1:0]}; e.b = {6'b0, c[3:2]}; e.imm = {6'b0, c[1:0]}; e.we = 1'b1;
        end
        return e;
    endfunction

    always @(negedge Clk) begin
        if (!Reset_n) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", sbq.size(), 1);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("sb_inA", inA, mon_e.a);
                    chk("sb_inB", inB, mon_e.b);
                    chk("sb_imm", immediate, mon_e.imm);
                    chk("sb_dst", dst_addr, mon_e.dst);
                    chk("sb_we", dst_we, mon_e.we);
                end
            end
            if (flush)
                sbq.delete();
            else if (in_valid && in_ready)
                sbq.push_back(model(mach_code, RegDst, MemtoReg, MemWrite, Branch));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [8:0] c, input logic rd, input logic ml,
                         input logic mw, input logic br);
        in_valid = 1'b1; mach_code = c;
        RegDst = rd; MemtoReg = ml; MemWrite = mw; Branch = br;
    endtask

    initial begin
        Reset_n = 0; flush = 0; in_valid = 0; mach_code = '0;
        RegDst = 1; MemtoReg = 0; MemWrite = 0; Branch = 0;
        out_ready = 1; wb_valid = 0; wb_addr = '0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_inA", inA, 0);
        chk("rst_dst_we", dst_we, 0);
        chk("rst_stall", stall_cnt, 0);
        step(); step(); Reset_n = 1; step();

        // REG class
        drive(9'b000_00_10_01, 1, 0, 0, 0);
        @(negedge Clk) chk("reg_in_ready", in_ready, 1);
        step(); in_valid = 0;
        @(negedge Clk);
        chk("reg_out_valid", out_valid, 1);
        chk("reg_inA", inA, 1);
        chk("reg_inB", inB, 2);
        chk("reg_imm", immediate, 1);
        chk("reg_dst", dst_addr, 1);
        chk("reg_we", dst_we, 1);
        step();
        @(negedge Clk) chk("drain_out_valid", out_valid, 0);
        wb_valid = 1; wb_addr = 2'd1; step(); wb_valid = 0;

        // IMM class, leaves r2 busy
        drive(9'b000_11_01_10, 0, 0, 0, 0);
        @(negedge Clk) chk("imm_in_ready", in_ready, 1);
        step(); in_valid = 0;
        @(negedge Clk);
        chk("imm_inA", inA, 2);
        chk("imm_inB", inB, 3);
        chk("imm_imm", immediate, 6);
        chk("imm_dst", dst_addr, 2);
        step();

        // RAW on r2, released by writeback one cycle later
        drive(9'b000_00_00_10, 1, 0, 0, 0);
        @(negedge Clk);
        chk("raw_in_ready", in_ready, 0);
        chk("raw_stall0", stall_cnt, 0);
        step(); step(); step();
        @(negedge Clk);
        chk("raw_stall3", stall_cnt, 3);
        wb_valid = 1; wb_addr = 2'd2;
        #1 chk("wb_no_bypass", in_ready, 0);
        step(); wb_valid = 0;
        @(negedge Clk);
        chk("wb_release", in_ready, 1);
        chk("raw_stall4", stall_cnt, 4);
        step(); in_valid = 0;
        wb_valid = 1; wb_addr = 2'd2; step(); wb_valid = 0;

        // backpressure: load r3 held, then a store waits
        out_ready = 0;
        drive(9'b000_00_00_11, 1, 1, 0, 0);
        @(negedge Clk) chk("bp_accept", in_ready, 1);
        step();
        drive(9'b000_10_01_00, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_dst", dst_addr, 3);
            chk("bp_we", dst_we, 1);
            step();
        end
        @(negedge Clk) chk("bp_stall7", stall_cnt, 7);
        out_ready = 1;
        #1 chk("bp_release", in_ready, 1);
        step();
        drive(9'b000_01_10_00, 1, 0, 0, 1);
        @(negedge Clk);
        chk("tp_in_ready_c", in_ready, 1);
        chk("tp_out_valid_c", out_valid, 1);
        step();
        drive(9'b000_00_01_01, 1, 0, 1, 0);
        @(negedge Clk);
        chk("tp_in_ready_d", in_ready, 1);
        chk("tp_out_valid_d", out_valid, 1);
        step(); in_valid = 0;
        @(negedge Clk) chk("tp_out_valid_last", out_valid, 1);
        step();
        wb_valid = 1; wb_addr = 2'd3; step(); wb_valid = 0;

        // set beats clear on r1
        drive(9'b000_00_00_01, 0, 0, 0, 0);
        @(negedge Clk) chk("sw_first", in_ready, 1);
        step();
        wb_valid = 1; wb_addr = 2'd1;
        @(negedge Clk) chk("sw_second", in_ready, 1);
        step(); wb_valid = 0;
        drive(9'b000_00_00_01, 1, 0, 0, 0);
        @(negedge Clk) chk("sw_busy_kept", in_ready, 0);
        step();

        // flush with r1, r2 busy and an output held
        drive(9'b000_00_00_10, 0, 0, 0, 0);
        @(negedge Clk) chk("fl_setup", in_ready, 1);
        step();
        out_ready = 0; flush = 1;
        drive(9'b000_00_00_00, 1, 0, 1, 0);
        @(negedge Clk);
        chk("fl_in_ready", in_ready, 0);
        chk("fl_held", out_valid, 1);
        step();
        flush = 0; out_ready = 1;
        drive(9'b000_00_10_01, 1, 0, 0, 0);
        @(negedge Clk);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_busy_clear", in_ready, 1);
        chk("fl_stall", stall_cnt, 8);
        step();

        // reset in the middle of a stall on r1
        drive(9'b000_00_00_01, 1, 0, 0, 0);
        @(negedge Clk) chk("rs_stalled", in_ready, 0);
        step(); step();
        @(negedge Clk) chk("rs_stall10", stall_cnt, 10);
        #2 Reset_n = 0;
        #1;
        chk("rs_in_ready", in_ready, 0);
        chk("rs_inA", inA, 0);
        chk("rs_inB", inB, 0);
        chk("rs_imm", immediate, 0);
        chk("rs_dst", dst_addr, 0);
        chk("rs_we", dst_we, 0);
        chk("rs_stall", stall_cnt, 0);
        in_valid = 0;
        step(); Reset_n = 1; step();
        chk("sb_leftover", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
